// File: rtl/alu_seq_ctrl_if.sv
// Request/response handshake bundle between the issue logic (master side)
// and the alu_seq_ctrl sequencer (slave side).
interface alu_seq_ctrl_if #(
    parameter int W = 32
);
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_acc;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;

    modport master (
        output req_valid, req_op, req_a, req_b, req_acc, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_acc, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencer for the alu datapath: loads operands, strobes capture, returns the result.
// Optional accumulator operand source is built only when ALU_SEQ_CTRL_ACC_EN is defined.
module alu_seq_ctrl #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_seq_ctrl_if.slave    bus,
    output logic [CNT_W-1:0] op_count,
    output logic [W-1:0]     alu_a0,
    output logic [W-1:0]     alu_b0,
    output logic [2:0]       alu_sel,
    output logic             alu_init_a,
    output logic             alu_init_b,
    output logic             alu_init_y,
    input  logic [W-1:0]     alu_y0
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LDA  = 3'd1;
    localparam logic [2:0] LDB  = 3'd2;
    localparam logic [2:0] EXEC = 3'd3;
    localparam logic [2:0] CAPT = 3'd4;
    localparam logic [2:0] SAMP = 3'd5;
    localparam logic [2:0] RESP = 3'd6;

    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;

    logic [2:0]       state_q, state_d;
    logic [W-1:0]     a0_q, a0_d;
    logic [W-1:0]     b0_q, b0_d;
    logic [2:0]       sel_q, sel_d;
    logic             init_a_q, init_a_d;
    logic             init_b_q, init_b_d;
    logic             init_y_q, init_y_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [W-1:0]     rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             accept;
    logic             handshake;
    logic             unary;
    logic [W-1:0]     operand_a;

    assign bus.req_ready = rst_n && (state_q == IDLE);
    assign accept        = bus.req_valid && bus.req_ready;
    assign handshake     = rsp_valid_q && bus.rsp_ready;
    assign unary         = (sel_q == OP_NOT) || (sel_q == OP_SHL);

`ifdef ALU_SEQ_CTRL_ACC_EN
    logic [W-1:0] acc_q, acc_d;

    // Acceptance reads acc_q, so a same-cycle update would still hand over the old value.
    assign acc_d     = handshake ? rsp_data_q : acc_q;
    assign operand_a = bus.req_acc ? acc_q : bus.req_a;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    logic unused_req_acc;

    assign unused_req_acc = bus.req_acc;
    assign operand_a      = bus.req_a;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = LDA;
            LDA:  state_d = unary ? EXEC : LDB;
            LDB:  state_d = EXEC;
            EXEC: state_d = CAPT;
            CAPT: state_d = SAMP;
            SAMP: state_d = RESP;
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes and rsp_valid are registered decodes of the state being entered.
    always_comb begin
        init_a_d    = (state_d == LDA);
        init_b_d    = (state_d == LDB);
        init_y_d    = (state_d == CAPT);
        rsp_valid_d = (state_d == RESP);
        a0_d        = accept ? operand_a : a0_q;
        b0_d        = accept ? bus.req_b : b0_q;
        sel_d       = accept ? bus.req_op : sel_q;
        rsp_data_d  = (state_q == SAMP) ? alu_y0 : rsp_data_q;
        count_d     = handshake ? count_q + CNT_W'(1) : count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a0_q        <= '0;
            b0_q        <= '0;
            sel_q       <= '0;
            init_a_q    <= 1'b0;
            init_b_q    <= 1'b0;
            init_y_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            a0_q        <= a0_d;
            b0_q        <= b0_d;
            sel_q       <= sel_d;
            init_a_q    <= init_a_d;
            init_b_q    <= init_b_d;
            init_y_q    <= init_y_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            count_q     <= count_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign op_count      = count_q;
    assign alu_a0        = a0_q;
    assign alu_b0        = b0_q;
    assign alu_sel       = sel_q;
    assign alu_init_a    = init_a_q;
    assign alu_init_b    = init_b_q;
    assign alu_init_y    = init_y_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: random and directed requests, a small ALU
// stand-in, and a per-cycle monitor comparing against a timing/result model.
module tb_alu_seq_ctrl;
    localparam int W     = 32;
    localparam int CNT_W = 4;
`ifdef ALU_SEQ_CTRL_ACC_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [CNT_W-1:0] op_count;
    logic [W-1:0]     alu_a0, alu_b0, alu_y0;
    logic [2:0]       alu_sel;
    logic             alu_init_a, alu_init_b, alu_init_y;

    always #5 clk = ~clk;

    alu_seq_ctrl_if #(.W(W)) bus ();

    alu_seq_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .op_count   (op_count),
        .alu_a0     (alu_a0),
        .alu_b0     (alu_b0),
        .alu_sel    (alu_sel),
        .alu_init_a (alu_init_a),
        .alu_init_b (alu_init_b),
        .alu_init_y (alu_init_y),
        .alu_y0     (alu_y0)
    );

    function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a | b;
            3'd3:    return a & b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return a << 1;
            default: return (a < b) ? W'(1) : ((a == b) ? W'(2) : W'(3));
        endcase
    endfunction

    // ALU stand-in: operand/result registers loaded by the strobes, never reset.
    logic [W-1:0] alu_a_r, alu_b_r, alu_y_r;
    always @(posedge clk) begin
        if (alu_init_a) alu_a_r <= alu_a0;
        if (alu_init_b) alu_b_r <= alu_b0;
        if (alu_init_y) alu_y_r <= ref_alu(alu_sel, alu_a_r, alu_b_r);
    end
    assign alu_y0 = alu_y_r;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         acc;
    } req_t;

    req_t         req_q[$];
    logic [W-1:0] rsp_q[$];
    logic [W-1:0] hs_log[$];

    int           t_acc = -100;
    int           lat_m = 6;
    int           cnt_m = 0;
    bit           bin_m, busy_m, pend_m, started, in_resp, exp_rdy;
    logic [W-1:0] hold_a, hold_b, data_m, acc_m, a_eff;
    logic [2:0]   hold_sel;
    req_t         r_m;

    // Monitor: compares every output each cycle, then advances the model.
    always @(negedge clk) begin
        in_resp = pend_m && (cyc >= t_acc + lat_m);
        exp_rdy = rst_n && !busy_m;
        if (started) begin
            chk("req_ready", bus.req_ready, exp_rdy);
            chk("init_a", alu_init_a, cyc == t_acc + 1);
            chk("init_b", alu_init_b, bin_m && (cyc == t_acc + 2));
            chk("init_y", alu_init_y, cyc == t_acc + lat_m - 2);
            chk("rsp_valid", bus.rsp_valid, in_resp);
            chk("rsp_data", bus.rsp_data, (in_resp && rsp_q.size() > 0) ? rsp_q[0] : data_m);
            chk("alu_a0", alu_a0, hold_a);
            chk("alu_b0", alu_b0, hold_b);
            chk("alu_sel", alu_sel, hold_sel);
            chk("op_count", op_count, cnt_m);
        end
        if (!rst_n) begin
            started  = 1'b1;
            busy_m   = 1'b0;
            pend_m   = 1'b0;
            bin_m    = 1'b0;
            t_acc    = -100;
            lat_m    = 6;
            hold_a   = '0;
            hold_b   = '0;
            hold_sel = '0;
            data_m   = '0;
            acc_m    = '0;
            cnt_m    = 0;
            rsp_q.delete();
            req_q.delete();
        end else if (started) begin
            if (in_resp && bus.rsp_ready) begin
                data_m = rsp_q.pop_front();
                acc_m  = data_m;
                hs_log.push_back(bus.rsp_data);
                cnt_m  = (cnt_m + 1) % (1 << CNT_W);
                pend_m = 1'b0;
                busy_m = 1'b0;
                $display("rsp  op_count_next=%0d data=%08h", cnt_m, bus.rsp_data);
            end
            if (bus.req_valid && exp_rdy) begin
                chk("req_queue", req_q.size() > 0, 1);
                if (req_q.size() > 0) begin
                    r_m      = req_q.pop_front();
                    a_eff    = (ACC && r_m.acc) ? acc_m : r_m.a;
                    t_acc    = cyc;
                    bin_m    = !(r_m.op == 3'd5 || r_m.op == 3'd6);
                    lat_m    = bin_m ? 6 : 5;
                    hold_a   = a_eff;
                    hold_b   = r_m.b;
                    hold_sel = r_m.op;
                    rsp_q.push_back(ref_alu(r_m.op, a_eff, r_m.b));
                    busy_m   = 1'b1;
                    pend_m   = 1'b1;
                    $display("req  cyc=%0d op=%0d a=%08h b=%08h acc=%0b exp=%08h", cyc, r_m.op, a_eff, r_m.b, r_m.acc, rsp_q[$]);
                end
            end
        end
    end

    // Consumer: 0 = always ready, 1 = random, 2 = stalled.
    int rdy_mode = 0;
    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.rsp_ready = 1'b1;
                1:       bus.rsp_ready = 1'($urandom_range(0, 1));
                default: bus.rsp_ready = 1'b0;
            endcase
        end
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic acc);
        req_t r;
        int   n = 0;
        @(posedge clk);
        #1;
        r.op = op; r.a = a; r.b = b; r.acc = acc;
        req_q.push_back(r);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_acc   = acc;
        @(negedge clk);
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("issue_accept", bus.req_ready, 1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_m && n < 300) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk("idle_ready", bus.req_ready, 1);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_acc   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_count", op_count, 0);
        chk("reset_ready", bus.req_ready, 1);

        rdy_mode = 0;
        issue(3'd0, 32'd5, 32'd3, 1'b0);
        wait_idle();
        chk("add_data", hs_log[$], 32'd8);
        chk("add_count", op_count, 1);

        issue(3'd5, 32'h0000FFFF, 32'h12345678, 1'b0);
        wait_idle();
        chk("not_data", hs_log[$], 32'hFFFF0000);

        // Compare under backpressure with a second request waiting behind it.
        rdy_mode = 2;
        issue(3'd7, 32'd7, 32'd7, 1'b0);
        fork
            begin
                repeat (16) @(posedge clk);
                rdy_mode = 0;
            end
        join_none
        issue(3'd7, 32'd9, 32'd4, 1'b0);
        wait_idle();
        chk("cmp_eq_data", hs_log[$-1], 32'd2);
        chk("cmp_gt_data", hs_log[$], 32'd3);

        // Reset while the sequence sits in EXEC.
        issue(3'd0, 32'd9, 32'd9, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_init_y", alu_init_y, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_a0", alu_a0, 0);
        chk("rst_count", op_count, 0);
        issue(3'd1, 32'd10, 32'd4, 1'b0);
        wait_idle();
        chk("sub_data", hs_log[$], 32'd6);
        chk("sub_count", op_count, 1);

        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            issue(3'($urandom_range(0, 7)), ra, rb, 1'($urandom_range(0, 1)));
        end
        wait_idle();

        do_reset(2);
        rdy_mode = 0;
        for (int i = 0; i < 17; i++) begin
            issue(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'b0);
        end
        wait_idle();
        chk("wrap_count", op_count, 1);

        do_reset(2);
        issue(3'd0, 32'd2, 32'd3, 1'b0);
        issue(3'd0, 32'd100, 32'd4, 1'b1);
        wait_idle();
        chk("acc_a0", alu_a0, ACC ? 32'd5 : 32'd100);
        chk("acc_data", hs_log[$], ACC ? 32'd9 : 32'd104);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencing controller for the `alu` datapath block. It accepts one operation request at a time over a valid/ready handshake and drives the ALU's operand-load, opcode and result-capture strobes in the required order. It samples the ALU result and returns it over a second valid/ready handshake. It sits between the instruction-issue logic and the `alu` instance, and is the only agent allowed to drive the ALU's `a0`, `b0`, `sel`, `init_a`, `init_b` and `init_y`.

## Interface
- `W`, default 32: operand/result width; must match the ALU datapath.
- `CNT_W`, default 16: width of the completed-operation counter.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_op`  in  3  ALU opcode: 000 add, 001 sub, 010 or, 011 and, 100 xor, 101 not-a, 110 shl1, 111 compare.
- `req_a`, `req_b`  in  W  operands.
- `req_acc`  in  1  use accumulator as operand a (see Configuration).
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes result.
- `rsp_data`  out  W  result.
- `op_count`  out  CNT_W  completed operations; wraps modulo 2^CNT_W.
- `alu_a0`, `alu_b0`  out  W  to ALU `a0` and `b0`.
- `alu_sel`  out  3  to ALU `sel`.
- `alu_init_a`, `alu_init_b`, `alu_init_y`  out  1  ALU load/capture strobes; single-cycle pulses.
- `alu_y0`  in  W  from ALU `y0`.

## Operation
- States: IDLE, LDA, LDB, EXEC, CAPT, SAMP, RESP.
- IDLE:
  - `req_ready` is 1.
  - On `req_valid` the request is accepted: `req_op`, `req_a` and `req_b` are registered into `alu_sel`, `alu_a0` and `alu_b0`.
  - Next state is LDA.
- LDA: `alu_init_a` is 1.
  - Next state is LDB.
  - Exception: for unary ops (101, 110) the next state is EXEC and LDB is skipped, so `alu_init_b` never pulses.
- LDB: `alu_init_b` is 1. Next state is EXEC.
- EXEC: no strobes; lets the ALU combinational result settle. Next state is CAPT.
- CAPT: `alu_init_y` is 1. Next state is SAMP.
- SAMP: `rsp_data <= alu_y0`. Next state is RESP.
- RESP:
  - `rsp_valid` is 1.
  - On `rsp_ready`: `op_count` increments and the next state is IDLE.
  - Otherwise the controller holds RESP with `rsp_data` stable.
- `alu_a0`, `alu_b0` and `alu_sel` hold their values from acceptance until the next acceptance.
- Strobes are registered, never high in two consecutive cycles, and are 0 in IDLE and RESP.
- No request is accepted outside IDLE.
- A result is not overwritten before it is consumed.
- Compare op (111): `rsp_data` passes through the ALU code unchanged — 1 for a<b, 2 for a==b, 3 for a>b.

## Timing
- Acceptance cycle is T; the request is accepted at the T edge.
- Binary ops: `alu_init_a` at T+1, `alu_init_b` at T+2, `alu_init_y` at T+4, `rsp_valid` first high at T+6.
- Unary ops: `alu_init_a` at T+1, `alu_init_y` at T+3, `rsp_valid` at T+5.
- Minimum issue interval: 7 cycles binary, 6 unary. The RESP→IDLE transition costs one cycle, so there is no back-to-back acceptance in RESP.
- `op_count` updates on the edge where `rsp_valid && rsp_ready`. It wraps from 2^CNT_W−1 to 0.
- Reset (`rst_n` low at a rising edge), from any state including mid-sequence:
  - state returns to IDLE;
  - `rsp_valid`, all `alu_init_*` strobes, `rsp_data`, `op_count`, `alu_a0`, `alu_b0`, `alu_sel` and the accumulator all go to 0;
  - `req_ready` is 0 while `rst_n` is low and 1 on the first cycle after release.
- ALU internal registers are not reset. The first result after reset is valid because every sequence reloads a (and b for binary ops).

## Configuration
- Macro `ALU_SEQ_CTRL_ACC_EN`.
- Defined:
  - a W-bit accumulator register updates with `rsp_data` at each `rsp_valid && rsp_ready` handshake;
  - when `req_acc` is 1 at acceptance, `alu_a0` takes the accumulator instead of `req_a`;
  - if the accumulator is updated by the handshake in the same cycle as an acceptance, the accepted operand is the pre-update value. This cannot occur with the FSM above; it is stated for robustness.
- Undefined: no accumulator register is built, and `req_acc` is ignored (port retained).

## Test plan
- Add: `req_op`=000, a=5, b=3, `rsp_ready`=1 → `alu_init_a` at T+1, `alu_init_b` at T+2, `alu_init_y` at T+4, `rsp_valid` at T+6, `rsp_data`=8, `op_count`=1.
- Unary: `req_op`=101, a=0x0000FFFF → `alu_init_b` never pulses, `rsp_valid` at T+5, `rsp_data`=0xFFFF0000.
- Backpressure and compare: `req_op`=111, a=7, b=7, `rsp_ready` held 0 for 10 cycles → `rsp_valid` stays 1 and `rsp_data` stays 2; `req_ready`=0 throughout; a second `req_valid` is not accepted until one cycle after the handshake.
- Reset mid-operation: assert `rst_n`=0 in EXEC → next cycle all outputs 0, no `alu_init_y` pulse; after release, a sub op 10−4 returns 6.
- Counter wrap: with CNT_W=4, complete 17 ops → `op_count`=1.
- With `ALU_SEQ_CTRL_ACC_EN`: add 2+3 (=5), then `req_acc`=1, op 000, b=4 → `alu_a0`=5, `rsp_data`=9. Without the macro, the same sequence gives `req_a`+4.
